// File: rtl/turn_sequencer.sv
// Turn controller for the shared message RAM: key synchronisers, START/P1/P2/RESULT FSM,
// and the single clock-synchronous RAM port (P1 writes words, P2 reads them back in order).
module turn_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_n,
    input  logic              done_n,
    input  logic [DATA_W-1:0] p1_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W:0]   p1_count,
    output logic [ADDR_W:0]   p2_addr,
    output logic [DATA_W-1:0] p2_word,
    output logic              p2_valid,
    output logic              p2_last,
    output logic              full
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_P1     = 2'd1,
        ST_P2     = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] next_sync;
    logic [1:0] done_sync;
    logic       next_prev;
    logic       done_prev;
    logic       next_ev;
    logic       done_ev;
    logic       next_go;
    logic       rd_stage1;
    logic       rd_stage2;
    logic       write_go;
    logic       read_go;
    logic       read_done;
    logic       clear_go;

    // Keys idle high, so the synchroniser and edge history reset to the released level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_sync <= 2'b11;
            done_sync <= 2'b11;
            next_prev <= 1'b1;
            done_prev <= 1'b1;
        end else begin
            next_sync <= {next_sync[0], next_n};
            done_sync <= {done_sync[0], done_n};
            next_prev <= next_sync[1];
            done_prev <= done_sync[1];
        end
    end

    assign next_ev = next_prev & ~next_sync[1];
    assign done_ev = done_prev & ~done_sync[1];
    assign next_go = next_ev & ~done_ev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= ST_START;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_START:  if (done_ev) nxt_state = ST_P1;
            ST_P1:     if (done_ev) nxt_state = ST_P2;
            ST_P2:     if (done_ev || (p2_valid && p2_last)) nxt_state = ST_RESULT;
            ST_RESULT: if (done_ev) nxt_state = ST_START;
            default:   nxt_state = ST_START;
        endcase
    end

    // A read occupies two cycles (address out, then RAM latency); a new one waits for it.
    always_comb begin
        state     = cur_state;
        full      = (p1_count == DEPTH_C);
        write_go  = (cur_state == ST_P1) && next_go && !full;
        read_go   = (cur_state == ST_P2) && next_go && (p2_addr < p1_count)
                    && !rd_stage1 && !rd_stage2;
        read_done = (cur_state == ST_P2) && rd_stage2 && !done_ev;
        clear_go  = (cur_state == ST_RESULT) && done_ev;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_wren  <= 1'b0;
            p1_count  <= '0;
            p2_addr   <= '0;
            p2_word   <= '0;
            p2_valid  <= 1'b0;
            p2_last   <= 1'b0;
            rd_stage1 <= 1'b0;
            rd_stage2 <= 1'b0;
        end else begin
            ram_wren  <= write_go;
            rd_stage1 <= read_go;
            rd_stage2 <= rd_stage1 && !done_ev;
            p2_valid  <= read_done;
            p2_last   <= read_done && (p2_addr == p1_count - ONE_C);
            if (write_go) begin
                ram_addr <= p1_count[ADDR_W-1:0];
                ram_data <= p1_data;
                p1_count <= p1_count + ONE_C;
            end else if (read_go) begin
                ram_addr <= p2_addr[ADDR_W-1:0];
            end
            if (read_done) begin
                p2_word <= ram_q;
                p2_addr <= p2_addr + ONE_C;
            end
            // Leaving RESULT starts a fresh game.
            if (clear_go) begin
                p1_count <= '0;
                p2_addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed key sequences with random data and hold
// times, checked against a queue-based model of the words each game stores and replays.
module tb_turn_sequencer;

    logic       clock;
    logic       reset;
    logic       next_n;
    logic       done_n;
    logic [9:0] p1_data;
    logic [9:0] ram_q;
    logic [1:0] state;
    logic [3:0] ram_addr;
    logic       ram_wren;
    logic [9:0] ram_data;
    logic [4:0] p1_count;
    logic [4:0] p2_addr;
    logic [9:0] p2_word;
    logic       p2_valid;
    logic       p2_last;
    logic       full;

    logic [9:0] mem [16];
    logic [9:0] model_words[$];
    int         exp_state;
    int         rd_idx;
    int         n_cmp;
    int         n_err;

    turn_sequencer #(.ADDR_W(4), .DATA_W(10), .DEPTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .next_n   (next_n),
        .done_n   (done_n),
        .p1_data  (p1_data),
        .ram_q    (ram_q),
        .state    (state),
        .ram_addr (ram_addr),
        .ram_wren (ram_wren),
        .ram_data (ram_data),
        .p1_count (p1_count),
        .p2_addr  (p2_addr),
        .p2_word  (p2_word),
        .p2_valid (p2_valid),
        .p2_last  (p2_last),
        .full     (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM: read data appears the cycle after the address.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_done(input int new_state);
        done_n = 1'b0;
        tick(2);
        check_output("done_pre_state", 32'(state), 32'(exp_state));
        tick(1);
        exp_state = new_state;
        if (new_state == 0) begin
            model_words.delete();
            rd_idx = 0;
        end
        check_output("done_state", 32'(state), 32'(exp_state));
        check_output("done_wren", 32'(ram_wren), 32'd0);
        check_output("done_p1_count", 32'(p1_count), 32'(model_words.size()));
        if (new_state == 0) check_output("done_p2_addr", 32'(p2_addr), 32'd0);
        done_n = 1'b1;
        tick(3);
    endtask

    task automatic apply_write(input logic [9:0] data, input int hold);
        int extra;
        int cnt;
        cnt = model_words.size();
        p1_data = data;
        next_n  = 1'b0;
        tick(2);
        check_output("wr_early", 32'(ram_wren), 32'd0);
        tick(1);
        if (cnt < 16) begin
            check_output("wr_wren", 32'(ram_wren), 32'd1);
            check_output("wr_addr", 32'(ram_addr), 32'(cnt));
            check_output("wr_data", 32'(ram_data), 32'(data));
            model_words.push_back(data);
        end else begin
            check_output("wr_full_no_wren", 32'(ram_wren), 32'd0);
        end
        check_output("wr_p1_count", 32'(p1_count), 32'(model_words.size()));
        check_output("wr_full", 32'(full), (model_words.size() == 16) ? 32'd1 : 32'd0);
        extra = 0;
        repeat (hold) begin
            tick(1);
            if (ram_wren) extra++;
        end
        next_n = 1'b1;
        repeat (3) begin
            tick(1);
            if (ram_wren) extra++;
        end
        check_output("wr_single_pulse", 32'(extra), 32'd0);
    endtask

    task automatic apply_read();
        int  idx;
        logic last;
        idx  = rd_idx;
        last = (idx == model_words.size() - 1);
        next_n = 1'b0;
        tick(3);
        check_output("rd_wren", 32'(ram_wren), 32'd0);
        check_output("rd_addr", 32'(ram_addr), 32'(idx));
        tick(1);
        check_output("rd_valid_early", 32'(p2_valid), 32'd0);
        tick(1);
        check_output("rd_valid", 32'(p2_valid), 32'd1);
        check_output("rd_word", 32'(p2_word), 32'(model_words[idx]));
        check_output("rd_last", 32'(p2_last), 32'(last));
        check_output("rd_p2_addr", 32'(p2_addr), 32'(idx + 1));
        rd_idx++;
        if (last) begin
            tick(1);
            exp_state = 3;
            check_output("rd_auto_result", 32'(state), 32'd3);
            check_output("rd_valid_pulse", 32'(p2_valid), 32'd0);
        end
        next_n = 1'b1;
        tick(3);
    endtask

    initial begin
        int extra;
        int n_rd;
        n_cmp     = 0;
        n_err     = 0;
        exp_state = 0;
        rd_idx    = 0;
        reset     = 1'b1;
        next_n    = 1'b1;
        done_n    = 1'b1;
        p1_data   = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick(2);
        check_output("rst_state", 32'(state), 32'd0);
        check_output("rst_p1_count", 32'(p1_count), 32'd0);
        check_output("rst_wren", 32'(ram_wren), 32'd0);
        check_output("rst_valid", 32'(p2_valid), 32'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] write three words, one with a long key hold");
        press_done(1);
        apply_write(10'h2A5, 1);
        apply_write(10'h001, 100);
        apply_write(10'h3FF, 1);

        $display("[TB] read them back in P2");
        press_done(2);
        apply_read();
        apply_read();
        apply_read();
        press_done(0);

        $display("[TB] fill to capacity with random words");
        press_done(1);
        for (int i = 0; i < 17; i++) apply_write(10'($urandom_range(0, 1023)), $urandom_range(1, 4));
        press_done(2);
        n_rd = $urandom_range(2, 6);
        for (int i = 0; i < n_rd; i++) apply_read();
        press_done(3);
        press_done(0);

        $display("[TB] simultaneous next and done in P1");
        press_done(1);
        apply_write(10'($urandom_range(0, 1023)), 2);
        apply_write(10'($urandom_range(0, 1023)), 1);
        next_n = 1'b0;
        done_n = 1'b0;
        tick(3);
        exp_state = 2;
        check_output("both_state", 32'(state), 32'd2);
        check_output("both_wren", 32'(ram_wren), 32'd0);
        check_output("both_p1_count", 32'(p1_count), 32'd2);
        next_n = 1'b1;
        done_n = 1'b1;
        tick(3);

        $display("[TB] reset in the middle of a P2 read");
        next_n = 1'b0;
        tick(4);
        reset = 1'b1;
        #1;
        check_output("mid_rst_state", 32'(state), 32'd0);
        check_output("mid_rst_addr", 32'(ram_addr), 32'd0);
        check_output("mid_rst_word", 32'(p2_word), 32'd0);
        check_output("mid_rst_p1_count", 32'(p1_count), 32'd0);
        check_output("mid_rst_p2_addr", 32'(p2_addr), 32'd0);
        check_output("mid_rst_valid", 32'(p2_valid), 32'd0);
        next_n = 1'b1;
        tick(2);
        reset = 1'b0;
        model_words.delete();
        rd_idx    = 0;
        exp_state = 0;
        extra = 0;
        repeat (8) begin
            tick(1);
            if (p2_valid) extra++;
        end
        check_output("mid_rst_no_valid", 32'(extra), 32'd0);
        check_output("mid_rst_state_after", 32'(state), 32'd0);

        $display("[TB] empty game: next in P2 has nothing to read");
        press_done(1);
        press_done(2);
        next_n = 1'b0;
        extra  = 0;
        repeat (6) begin
            tick(1);
            if (p2_valid || ram_wren) extra++;
        end
        check_output("empty_no_access", 32'(extra), 32'd0);
        check_output("empty_addr", 32'(ram_addr), 32'd0);
        check_output("empty_state", 32'(state), 32'd2);
        next_n = 1'b1;
        tick(3);
        press_done(3);
        press_done(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
